instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder/control block.
- Owns the PC, issues word fetches to instruction memory over a request/response handshake, and registers the returned instruction.
- Presents one instruction per execute slot with `stale` low. Keeps `stale` high while a fetch is outstanding, while downstream holds, or after a fault.
- Applies branch redirects from the branch comparator and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), value of `instruction` after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (= pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  fetched instruction word
- branch_taken  in  1  redirect request, qualified by the execute slot
- branch_target  in  32  redirect PC
- hold  in  1  downstream stall; freezes current instruction
- pc  out  32  PC of `instruction`
- pc_plus4  out  32  pc + 4, modulo 2^32
- instruction  out  32  instruction to decoder/control
- stale  out  1  high = no valid instruction this cycle (drives control stale)
- fetch_err  out  1  sticky misaligned-target fault
- instret  out  32  retired-instruction count

Behaviour:
States:
- BOOT, REQ, WAIT, EXEC, FAULT. Binary encoding; BOOT = 0.

Reset (asynchronous, takes effect immediately, including mid-fetch):
- State = BOOT, pc = RESET_PC, instruction = NOP_INSTR, instret = 0, fetch_err = 0.
- Outputs during reset: imem_req = 0, stale = 1.

Transitions:
- BOOT: imem_req = 0. Next state REQ, unconditionally.
- REQ: imem_req = 1, imem_addr = pc, held stable until accepted.
  - imem_ready = 1 → WAIT.
  - imem_rvalid seen in REQ is ignored.
- WAIT: imem_req = 0.
  - imem_rvalid = 1 → instruction <= imem_rdata, go to EXEC.
  - Otherwise remain in WAIT.
  - There is no timeout.
- EXEC: stale = 0 whenever hold = 0.
  - hold = 1: stay in EXEC with stale = 1. pc and instruction are frozen; branch inputs and instret are ignored.
  - hold = 0, retire this cycle:
    - instret += 1, wrapping 0xFFFF_FFFF → 0.
    - Next pc = branch_taken ? branch_target : pc + 4, with wrap at 2^32.
    - If that next pc has bits [1:0] != 0: fetch_err <= 1, go to FAULT, pc unchanged.
    - Otherwise go to REQ.
- FAULT: imem_req = 0, stale = 1. Only reset exits this state.

Output rules:
- stale = 1 in every state except EXEC with hold = 0.
- instruction and pc hold their last values in every state; they are never cleared except by reset.
- Control treats the decode as a bubble whenever stale = 1.

Timing and boundary conditions:
- Throughput with zero-wait memory (ready same cycle, rvalid next cycle): 3 cycles per instruction (REQ, WAIT, EXEC).
- Memory contract: rvalid is returned strictly after acceptance, one response per accepted request, in order.
- branch_taken and hold both high: hold wins and the branch is not taken. The branch unit must re-present it on the next retire cycle (its inputs are stable because the instruction is frozen).
- branch_target = pc: legal; the same word is refetched.
- pc = 0xFFFF_FFFC with no branch: next pc = 0x0000_0000, no fault.
- A response still in flight across reset is the memory's responsibility; imem shares rst_n.

Decomposition:
- Shared header "fetch_codes.h", next to opcodes.h: state encodings (BOOT/REQ/WAIT/EXEC/FAULT) and NOP_INSTR.
- One natural sub-module: event_counter (32-bit enable-driven wrapping counter, async active-low reset), used for instret and reusable for future cycle/perf counters.
- The FSM, PC register and instruction register stay in instruction_fetch.

Test Plan:
1. Reset release, zero-wait memory returning 0x00500093 at address 0 → first cycle BOOT with imem_req = 0. REQ at cycle 1 with addr 0x0. Cycle 3: stale = 0, instruction = 0x00500093, pc = 0, then pc = 4; instret = 1.
2. Memory withholds imem_ready for 4 cycles and rvalid for 3 → imem_addr stable throughout; stale = 1 the whole time; exactly one retire per instruction.
3. In EXEC at pc = 0x10 with branch_taken = 1, target = 0x40 → next imem_addr = 0x40. With branch_taken = 0 → next imem_addr = 0x14.
4. hold = 1 for 2 cycles in EXEC while branch_taken = 1 → stale = 1, pc and instruction frozen, instret unchanged. On release: redirect taken, instret += 1.
5. branch_target = 0x42 → fetch_err = 1, stale stays 1, imem_req stays 0 for 10 cycles. Assert rst_n = 0 → everything returns to reset values.
6. Preload instret via 0xFFFF_FFFF retires (or a force) plus one more retire → instret = 0. Also pc = 0xFFFF_FFFC without a branch → next addr = 0x0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the fetch stage: FSM state codes and the reset NOP.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    // addi x0,x0,0 -- harmless instruction shown to decode before the first fetch.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // A fetch address must be word aligned; anything else is a fault.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_event_counter.sv
// Enable-driven wrapping event counter (retired instructions, cycles, perf events).
module event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count one event per enabled cycle; wraps naturally at 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over a req/ready +
// rvalid handshake, presents it to decode, applies branch redirects and counts
// retired instructions.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        hold,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instruction,
    output logic        stale,
    output logic        fetch_err,
    output logic [31:0] instret
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         err_q, err_d;
    logic         retire;
    logic [31:0]  next_pc;

    // hold wins over branch_taken: a frozen instruction must not redirect.
    assign next_pc = branch_taken ? branch_target : pc_q + 32'd4;

    // State, PC, instruction and fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Next-state and handshake/output decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        err_d    = err_q;
        imem_req = 1'b0;
        stale    = 1'b1;
        retire   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                // Address comes straight from pc_q, so it is stable until accepted.
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!hold) begin
                    stale  = 1'b0;
                    retire = 1'b1;
                    if (is_misaligned(next_pc)) begin
                        // Faulting redirect retires the current instruction but
                        // leaves pc on it for diagnosis.
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    event_counter #(.WIDTH(32)) u_instret (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (retire),
        .count_o (instret)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instruction = instr_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable memory model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        hold;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
    logic        stale;
    logic        fetch_err;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fails  = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hold          (hold),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instruction   (instruction),
        .stale         (stale),
        .fetch_err     (fetch_err),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address 0 holds addi x1,x0,5; elsewhere a tagged pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'hA500_0013;
    endfunction

    // Memory model: all decisions at negedge; handshakes seen at the following
    // posedge are recorded in flags and applied at the next negedge.
    int          rdy_lat = 0;
    int          rv_lat  = 0;
    int          rcnt = 0;
    int          wcnt = 0;
    bit          pend = 0;
    logic [31:0] paddr = 32'h0;
    bit          req_flag = 0;
    bit          acc_flag = 0;
    bit          rv_flag  = 0;
    logic [31:0] acc_addr = 32'h0;

    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; rcnt = 0; wcnt = 0;
            imem_ready = 1'b0; imem_rvalid = 1'b0;
        end else begin
            if (acc_flag) begin
                pend = 1; paddr = acc_addr; wcnt = 0; rcnt = 0;
            end else if (req_flag) begin
                rcnt++;
            end
            if (rv_flag) pend = 0;
            else if (pend && !acc_flag) wcnt++;
            imem_ready  = imem_req && (rcnt >= rdy_lat);
            imem_rvalid = pend && (wcnt >= rv_lat);
            imem_rdata  = imem_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;
        end
        req_flag = rst_n && imem_req;
        acc_flag = rst_n && imem_req && imem_ready;
        acc_addr = imem_addr;
        rv_flag  = rst_n && imem_rvalid;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        hold = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        rdy_lat = 0; rv_lat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_exec(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stale === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({imem_req, stale, fetch_err} !== 3'b010) begin
            n_fails++; $display("FAIL reset_ctrl: req/stale/err=%b want 010", {imem_req, stale, fetch_err});
        end
        n_checks++;
        if (pc !== 32'h0 || instruction !== 32'h0000_0013 || instret !== 32'h0) begin
            n_fails++; $display("FAIL reset_regs: pc=%h instr=%h instret=%h want 0/00000013/0", pc, instruction, instret);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || stale !== 1'b1) begin
            n_fails++; $display("FAIL boot_cycle: req=%b stale=%b want 0 1", imem_req, stale);
        end
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fails++; $display("FAIL req_cycle1: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (stale !== 1'b0 || instruction !== 32'h0050_0093 || pc !== 32'h0 || pc_plus4 !== 32'h4 || instret !== 32'h0) begin
            n_fails++; $display("FAIL first_exec: stale=%b instr=%h pc=%h pc4=%h instret=%h", stale, instruction, pc, pc_plus4, instret);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h4 || imem_addr !== 32'h4 || imem_req !== 1'b1 || instret !== 32'h1) begin
            n_fails++; $display("FAIL first_retire: pc=%h addr=%h req=%b instret=%h want 4 4 1 1", pc, imem_addr, imem_req, instret);
        end
    endtask

    task automatic test_wait_states();
        int reqc = 0;
        int waitc = 0;
        bit addr_bad = 0;
        bit cnt_bad = 0;
        bit ok = 0;
        do_reset();
        rdy_lat = 4; rv_lat = 3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stale === 1'b0) begin
                ok = 1;
                break;
            end
            if (imem_req === 1'b1) begin
                reqc++;
                if (imem_addr !== 32'h0) addr_bad = 1;
            end else begin
                waitc++;
            end
            if (instret !== 32'h0) cnt_bad = 1;
        end
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL slow_exec_timeout: stale never dropped"); end
        n_checks++;
        if (reqc != 5 || waitc != 4) begin
            n_fails++; $display("FAIL slow_cycles: req=%0d wait=%0d want 5 4", reqc, waitc);
        end
        n_checks++;
        if (addr_bad || cnt_bad) begin
            n_fails++; $display("FAIL slow_stable: addr_bad=%b instret_bad=%b want 0 0", addr_bad, cnt_bad);
        end
        n_checks++;
        if (instruction !== 32'h0050_0093 || instret !== 32'h0) begin
            n_fails++; $display("FAIL slow_instr: instr=%h instret=%h want 00500093 0", instruction, instret);
        end
        wait_exec(ok);
        n_checks++;
        if (!ok || instruction !== 32'hA500_0017 || pc !== 32'h4 || instret !== 32'h1) begin
            n_fails++; $display("FAIL slow_second: ok=%b instr=%h pc=%h instret=%h want 1 a5000017 4 1", ok, instruction, pc, instret);
        end
        @(negedge clk);
        n_checks++;
        if (instret !== 32'h2 || imem_addr !== 32'h8) begin
            n_fails++; $display("FAIL slow_retire: instret=%h addr=%h want 2 8", instret, imem_addr);
        end
    endtask

    task automatic test_branch();
        bit ok = 0;
        bit all_ok = 1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_exec(ok);
            if (!ok) all_ok = 0;
        end
        n_checks++;
        if (!all_ok || pc !== 32'h10 || instruction !== 32'hA500_0003) begin
            n_fails++; $display("FAIL br_reach: ok=%b pc=%h instr=%h want 1 10 a5000003", all_ok, pc, instruction);
        end
        @(negedge clk);
        n_checks++;
        if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin
            n_fails++; $display("FAIL br_not_taken: addr=%h req=%b want 14 1", imem_addr, imem_req);
        end
        wait_exec(ok);
        branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        n_checks++;
        if (!ok || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            n_fails++; $display("FAIL br_taken: ok=%b addr=%h req=%b want 1 40 1", ok, imem_addr, imem_req);
        end
        branch_taken = 1'b0;
        wait_exec(ok);
        branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        n_checks++;
        if (!ok || imem_addr !== 32'h40 || instret !== 32'h7) begin
            n_fails++; $display("FAIL br_self: ok=%b addr=%h instret=%h want 1 40 7", ok, imem_addr, instret);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_hold();
        bit ok = 0;
        bit frz_bad = 0;
        do_reset();
        wait_exec(ok);
        hold = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        #1;
        n_checks++;
        if (!ok || stale !== 1'b1) begin
            n_fails++; $display("FAIL hold_stale: ok=%b stale=%b want 1 1", ok, stale);
        end
        repeat (2) begin
            @(negedge clk);
            if (stale !== 1'b1 || pc !== 32'h0 || instruction !== 32'h0050_0093 || instret !== 32'h0 || imem_req !== 1'b0)
                frz_bad = 1;
        end
        n_checks++;
        if (frz_bad) begin
            n_fails++; $display("FAIL hold_frozen: pc=%h instr=%h instret=%h stale=%b", pc, instruction, instret, stale);
        end
        hold = 1'b0;
        #1;
        n_checks++;
        if (stale !== 1'b0) begin
            n_fails++; $display("FAIL hold_release: stale=%b want 0", stale);
        end
        @(negedge clk);
        n_checks++;
        if (imem_addr !== 32'h80 || pc !== 32'h80 || instret !== 32'h1) begin
            n_fails++; $display("FAIL hold_redirect: addr=%h pc=%h instret=%h want 80 80 1", imem_addr, pc, instret);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_fault();
        bit ok = 0;
        bit flt_bad = 0;
        do_reset();
        wait_exec(ok);
        branch_taken = 1'b1; branch_target = 32'h42;
        @(negedge clk);
        n_checks++;
        if (!ok || fetch_err !== 1'b1 || pc !== 32'h0 || stale !== 1'b1 || imem_req !== 1'b0 || instret !== 32'h1) begin
            n_fails++; $display("FAIL fault_entry: err=%b pc=%h stale=%b req=%b instret=%h want 1 0 1 0 1", fetch_err, pc, stale, imem_req, instret);
        end
        branch_taken = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (stale !== 1'b1 || imem_req !== 1'b0 || fetch_err !== 1'b1) flt_bad = 1;
        end
        n_checks++;
        if (flt_bad) begin
            n_fails++; $display("FAIL fault_sticky: stale=%b req=%b err=%b want 1 0 1", stale, imem_req, fetch_err);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fetch_err !== 1'b0 || instret !== 32'h0 || pc !== 32'h0 || instruction !== 32'h0000_0013 || stale !== 1'b1 || imem_req !== 1'b0) begin
            n_fails++; $display("FAIL fault_reset: err=%b instret=%h pc=%h instr=%h stale=%b req=%b", fetch_err, instret, pc, instruction, stale, imem_req);
        end
    endtask

    task automatic test_wrap();
        bit ok = 0;
        do_reset();
        wait_exec(ok);
        @(negedge clk);
        force dut.u_instret.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_instret.count_q;
        wait_exec(ok);
        n_checks++;
        if (!ok || instret !== 32'hFFFF_FFFF) begin
            n_fails++; $display("FAIL wrap_preload: ok=%b instret=%h want 1 ffffffff", ok, instret);
        end
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        n_checks++;
        if (instret !== 32'h0 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fails++; $display("FAIL wrap_instret: instret=%h addr=%h want 0 fffffffc", instret, imem_addr);
        end
        branch_taken = 1'b0;
        wait_exec(ok);
        n_checks++;
        if (!ok || pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || instruction !== 32'h5AFF_FFEF) begin
            n_fails++; $display("FAIL wrap_top: ok=%b pc=%h pc4=%h instr=%h want 1 fffffffc 0 5affffef", ok, pc, pc_plus4, instruction);
        end
        @(negedge clk);
        n_checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || fetch_err !== 1'b0 || instret !== 32'h1) begin
            n_fails++; $display("FAIL wrap_pc: addr=%h req=%b err=%b instret=%h want 0 1 0 1", imem_addr, imem_req, fetch_err, instret);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hold = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        test_reset();
        test_wait_states();
        test_branch();
        test_hold();
        test_fault();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
